// File: rtl/response_misr_checker_pkg.sv
// Shared types, default constants and the MISR step function for the response checker.
package rmc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SKIP,
        CAPTURE,
        COMPARE,
        DONE
    } rmc_state_e;

    localparam int unsigned MISR_MAX_W = 64;
    localparam logic [31:0] DEF_POLY   = 32'h04C11DB7;
    localparam logic [31:0] DEF_SEED   = 32'h00000000;

    // Galois MISR step on a MISR_MAX_W container; bits at and above 'width' are cleared.
    function automatic logic [MISR_MAX_W-1:0] misr_step(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] data,
        input logic [MISR_MAX_W-1:0] poly,
        input int unsigned           width
    );
        logic [MISR_MAX_W-1:0] w_top;
        logic [MISR_MAX_W-1:0] w_res;
        w_top = sig >> (width - 1);
        w_res = (sig << 1) ^ (w_top[0] ? poly : '0) ^ data;
        w_res = w_res & ~({MISR_MAX_W{1'b1}} << width);
        return w_res;
    endfunction

endpackage

// File: rtl/response_misr_checker_misr_reg.sv
// WIDTH-bit MISR register: load seed, absorb one word per enabled cycle, otherwise hold.
module misr_reg
    import rmc_pkg::*;
#(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_sig
);

    logic [WIDTH-1:0] r_sig;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_next = WIDTH'(misr_step(MISR_MAX_W'(r_sig), MISR_MAX_W'(i_data),
                                  MISR_MAX_W'(POLY), WIDTH));
    end

    // Load has priority so a re-arm never mixes the old signature into the new run.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sig <= SEED;
        end else if (i_load) begin
            r_sig <= SEED;
        end else if (i_step) begin
            r_sig <= w_next;
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/response_misr_checker.sv
// Response compactor: skips a warm-up window, folds a capture window into a MISR,
// then compares the signature against a golden value.
module response_misr_checker
    import rmc_pkg::*;
#(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED),
    parameter int unsigned      CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_skip_cycles,
    input  logic [CNT_W-1:0] i_capture_len,
    input  logic [WIDTH-1:0] i_dut_out,
    input  logic [WIDTH-1:0] i_golden,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [WIDTH-1:0] o_signature
);

    rmc_state_e       r_state;
    logic [CNT_W-1:0] r_skip_cnt;
    logic [CNT_W-1:0] r_cap_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    logic             w_armable;
    logic             w_load;
    logic             w_step;
    logic [WIDTH-1:0] w_sig;

    assign w_armable = (r_state == IDLE) || (r_state == DONE);
    assign w_load    = i_start && !i_abort && w_armable;
    assign w_step    = (r_state == CAPTURE) && !i_abort;

    misr_reg #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_load),
        .i_step (w_step),
        .i_data (i_dut_out),
        .o_sig  (w_sig)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_skip_cnt <= '0;
            r_cap_cnt  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Abort beats start and leaves the signature and pass flag untouched.
            if (i_abort) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE, DONE: begin
                        if (i_start) begin
                            r_skip_cnt <= i_skip_cycles;
                            r_cap_cnt  <= i_capture_len;
                            r_pass     <= 1'b0;
                            r_busy     <= 1'b1;
                            if (i_skip_cycles != '0) begin
                                r_state <= SKIP;
                            end else if (i_capture_len != '0) begin
                                r_state <= CAPTURE;
                            end else begin
                                r_state <= COMPARE;
                            end
                        end
                    end
                    SKIP: begin
                        r_skip_cnt <= r_skip_cnt - CNT_W'(1);
                        if (r_skip_cnt == CNT_W'(1)) begin
                            r_state <= (r_cap_cnt != '0) ? CAPTURE : COMPARE;
                        end
                    end
                    CAPTURE: begin
                        r_cap_cnt <= r_cap_cnt - CNT_W'(1);
                        if (r_cap_cnt == CNT_W'(1)) begin
                            r_state <= COMPARE;
                        end
                    end
                    COMPARE: begin
                        r_pass  <= (w_sig == i_golden);
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_signature = w_sig;

endmodule

// File: tb/tb_response_misr_checker.sv
// Directed bench: two checker instances (SEED=0 and SEED=32'h80000000) share stimulus.
module tb_response_misr_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] skip_cycles;
    logic [15:0] capture_len;
    logic [31:0] dut_out;
    logic [31:0] golden;

    logic        busy,  done,  pass;
    logic [31:0] sig;
    logic        busy_s, done_s, pass_s;
    logic [31:0] sig_s;

    int checks = 0;
    int errors = 0;
    int lat;
    logic saw_done;

    always #5 clk = ~clk;

    response_misr_checker #(
        .WIDTH (32),
        .POLY  (32'h04C11DB7),
        .SEED  (32'h00000000),
        .CNT_W (16)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_abort       (abort),
        .i_skip_cycles (skip_cycles),
        .i_capture_len (capture_len),
        .i_dut_out     (dut_out),
        .i_golden      (golden),
        .o_busy        (busy),
        .o_done        (done),
        .o_pass        (pass),
        .o_signature   (sig)
    );

    response_misr_checker #(
        .WIDTH (32),
        .POLY  (32'h04C11DB7),
        .SEED  (32'h80000000),
        .CNT_W (16)
    ) dut_s (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_abort       (abort),
        .i_skip_cycles (skip_cycles),
        .i_capture_len (capture_len),
        .i_dut_out     (dut_out),
        .i_golden      (golden),
        .o_busy        (busy_s),
        .o_done        (done_s),
        .o_pass        (pass_s),
        .o_signature   (sig_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns the number of negedges waited; stops at the budget so a stuck DUT cannot hang.
    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        skip_cycles = 16'd0;
        capture_len = 16'd0;
        dut_out     = 32'h0;
        golden      = 32'h0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_pass", {31'b0, pass}, 32'd0);
        chk("rst_sig", sig, 32'h00000000);
        chk("rst_sig_seed", sig_s, 32'h80000000);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'b0, busy}, 32'd0);

        // Basic fold: 1 then 0 -> 2, done 4 clks after start
        start = 1'b1; skip_cycles = 16'd0; capture_len = 16'd2;
        @(negedge clk);
        start = 1'b0; dut_out = 32'h00000001;
        chk("fold_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        dut_out = 32'h00000000;
        chk("fold_sig1", sig, 32'h00000001);
        @(negedge clk);
        chk("fold_nodone3", {31'b0, done}, 32'd0);
        @(negedge clk);
        chk("fold_done4", {31'b0, done}, 32'd1);
        chk("fold_sig", sig, 32'h00000002);
        chk("fold_pass", {31'b0, pass}, 32'd0);
        @(negedge clk);
        chk("fold_done_pulse", {31'b0, done}, 32'd0);
        chk("fold_sig_hold", sig, 32'h00000002);

        // Single word with matching golden
        golden = 32'hABCDEFAB; capture_len = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; dut_out = 32'hABCDEFAB;
        wait_done(20, lat);
        chk("single_lat", lat + 1, 32'd3);
        chk("single_sig", sig, 32'hABCDEFAB);
        chk("single_pass", {31'b0, pass}, 32'd1);

        // Feedback tap: seed MSB set, zero data
        golden = 32'h0; capture_len = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; dut_out = 32'h0;
        wait_done(20, lat);
        chk("tap_lat", lat + 1, 32'd3);
        chk("tap_sig_seed", sig_s, 32'h04C11DB7);
        chk("tap_pass_seed", {31'b0, pass_s}, 32'd0);
        chk("tap_sig_zero", sig, 32'h00000000);
        chk("tap_pass_zero", {31'b0, pass}, 32'd1);

        // Skip window: three ignored words, busy for 5 clks
        golden = 32'h12345678; skip_cycles = 16'd3; capture_len = 16'd1;
        dut_out = 32'h11111111; start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (i == 3) dut_out = 32'h12345678;
            chk("skip_busy", {31'b0, busy}, 32'd1);
            chk("skip_nodone", {31'b0, done}, 32'd0);
        end
        @(negedge clk);
        chk("skip_busy_end", {31'b0, busy}, 32'd0);
        chk("skip_done", {31'b0, done}, 32'd1);
        chk("skip_sig", sig, 32'h12345678);
        chk("skip_pass", {31'b0, pass}, 32'd1);

        // Zero length: done 2 clks after start, signature stays SEED
        golden = 32'h0; skip_cycles = 16'd0; capture_len = 16'd0; dut_out = 32'hFFFFFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zero_nodone1", {31'b0, done}, 32'd0);
        chk("zero_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("zero_done2", {31'b0, done}, 32'd1);
        chk("zero_sig", sig, 32'h00000000);
        chk("zero_pass", {31'b0, pass}, 32'd1);

        // Re-arm from DONE; a start during CAPTURE must be ignored
        start = 1'b1; capture_len = 16'd2;
        @(negedge clk);
        chk("rearm_busy", {31'b0, busy}, 32'd1);
        chk("rearm_pass_clr", {31'b0, pass}, 32'd0);
        start = 1'b0; dut_out = 32'h00000005;
        @(negedge clk);
        start = 1'b1; dut_out = 32'h00000007; capture_len = 16'd0; skip_cycles = 16'd9;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_ign", {31'b0, busy}, 32'd1);
        chk("busy_start_sig", sig, 32'h0000000D);
        @(negedge clk);
        chk("busy_start_done", {31'b0, done}, 32'd1);
        chk("busy_start_sig2", sig, 32'h0000000D);

        // Abort during CAPTURE: back to IDLE, signature held, no done
        skip_cycles = 16'd0; capture_len = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0; dut_out = 32'h00000003;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_sig_hold", sig, 32'h00000003);
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        chk("abort_no_done", {31'b0, saw_done}, 32'd0);

        // start and abort together: abort wins, nothing loads
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", {31'b0, busy}, 32'd0);
        chk("sa_sig_hold", sig, 32'h00000003);

        // Asynchronous reset mid-SKIP
        skip_cycles = 16'd6; capture_len = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_pass", {31'b0, pass}, 32'd0);
        chk("arst_sig", sig, 32'h00000000);
        chk("arst_sig_seed", sig_s, 32'h80000000);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            saw_done = saw_done | done | busy;
        end
        chk("arst_quiet", {31'b0, saw_done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/response_misr_checker.md
Name: response_misr_checker

Overview:
- On-chip response compactor and checker for the random-design tops (WIDTH-bit out bus).
- It sits on the opposite end of the stimulus path: it consumes the DUT output stream instead of driving the DUT input.
- It skips a programmable warm-up period, then folds a programmable number of output words into a MISR signature.
- It compares the signature against a golden value and reports pass/fail, so FPGA runs self-check without a waveform dump.

Parameters:
- WIDTH, 32, data and signature width.
- POLY, 32'h04C11DB7, MISR feedback polynomial (Galois taps), truncated to WIDTH.
- SEED, 0, signature value loaded on reset and on each accepted start.
- CNT_W, 16, width of the skip and capture counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a run; honoured only in IDLE or DONE.
- abort  input  1  synchronous; returns to IDLE from any state; no done pulse.
- skip_cycles  input  CNT_W  warm-up words to ignore; sampled at start.
- capture_len  input  CNT_W  words to compact; sampled at start.
- dut_out  input  WIDTH  DUT response word, sampled every clk.
- golden  input  WIDTH  expected signature; sampled in COMPARE.
- busy  output  1  high in SKIP, CAPTURE and COMPARE.
- done  output  1  one-cycle pulse on entry to DONE.
- pass  output  1  compare result; valid and held while in DONE.
- signature  output  WIDTH  current MISR value.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, busy=0, done=0, pass=0, signature=SEED, counters=0.
- MISR step: sig_next = (sig<<1) ^ (sig[WIDTH-1] ? POLY : 0) ^ dut_out. Truncate to WIDTH. No carries.
- FSM states and transitions:
  - IDLE: start=1 latches skip_cycles and capture_len, loads sig=SEED and clears pass. Next state is SKIP if skip_cycles!=0, else CAPTURE if capture_len!=0, else COMPARE.
  - SKIP: counts down one per clk and ignores dut_out. When the count reaches 1, next state is CAPTURE, or COMPARE if capture_len==0. Exactly skip_cycles words are discarded.
  - CAPTURE: absorbs dut_out with one MISR step per clk, for exactly capture_len clks. The first absorbed word is the one present on the first cycle in CAPTURE.
  - COMPARE: single cycle. pass <= (sig==golden). Next state is DONE.
  - DONE: done=1 for the entry cycle only. pass and signature are held. start behaves as in IDLE (re-arm directly).
- Latency: start to done = 1 + skip_cycles + capture_len + 1 clks.
- start while busy: ignored. Latched lengths and the current run are unaffected.
- start and abort in the same cycle: abort wins. State goes to IDLE; sig and pass are held.
- Zero-length capture: signature equals SEED at compare.
- Counters load full CNT_W values. Maximum run is 2^CNT_W-1 words per phase; there is no wrap.
- rst asserted mid-run: immediate return to reset values. No done pulse.

Decomposition:
- Shared package rmc_pkg holds:
  - state enum {IDLE, SKIP, CAPTURE, COMPARE, DONE};
  - default POLY and SEED constants;
  - function misr_step(sig, data, poly).
- One natural sub-module: misr_reg, the WIDTH-bit register with load-seed, enable-step and hold controls, instantiated once. The FSM and counters stay in response_misr_checker.

Test Plan:
- Basic fold: SEED=0, skip=0, len=2, dut_out=32'h00000001 then 32'h00000000 -> signature 32'h00000002. done pulses 4 clks after start.
- Single word: SEED=0, skip=0, len=1, dut_out=32'hABCDEFAB, golden=32'hABCDEFAB -> pass=1, signature=32'hABCDEFAB.
- Feedback tap: SEED=32'h80000000 (override), len=1, dut_out=0 -> signature=32'h04C11DB7. With golden=0 -> pass=0.
- Skip window: skip=3, len=1, dut_out=32'h11111111 for 3 clks then 32'h12345678 -> signature 32'h12345678 (SEED=0). busy high 5 clks.
- Zero length plus re-arm: len=0, skip=0, golden=0 -> pass=1, done 2 clks after start. start in DONE immediately begins a new run. start during CAPTURE is ignored.
- Abort and reset: abort during CAPTURE -> IDLE, no done pulse. rst pulse mid-SKIP -> busy=0, pass=0, signature=SEED without waiting for a clk edge.
